// File: rtl/dwrite_ctrl_if.sv
// Write-side bus between the capture writer and the SDRAM controller.
interface dwrite_ctrl_if;
    logic        wr_req;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_valid
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_valid
    );
endinterface

// File: rtl/dwrite_ctrl.sv
// Sample capture FIFO that bursts words into SDRAM at cap_base + offset.
// Optional macro DWRITE_RING_EN: ring-buffer capture that only cap_stop ends.
module dwrite_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_TH   = 8
) (
    input  logic          sdram_clk,
    input  logic          sdram_rst,
    input  logic          sd_init_done,
    input  logic          cap_start,
    input  logic          cap_stop,
    input  logic [31:0]   cap_base,
    input  logic [31:0]   cap_depth,
    input  logic [15:0]   din,
    input  logic          din_en,
    dwrite_ctrl_if.master wr,
    output logic          cap_busy,
    output logic          cap_done,
    output logic          fifo_ovf,
    output logic [31:0]   wr_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef DWRITE_RING_EN
    localparam bit RING = 1'b1;
`else
    localparam bit RING = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, FILL, WRITE, DONE
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level, level_nx;
    logic [31:0]   base, depth, offset, rx_cnt;
    logic [31:0]   offset_nx, wr_cnt_nx;
    logic          stopping;
    logic          busy, start, stop_now;
    logic          full, empty, want, push, drop, pop;

    assign busy     = state inside {WAIT_INIT, FILL, WRITE};
    assign start    = cap_start && (state == IDLE || state == DONE);
    assign stop_now = busy && (stopping || cap_stop);
    assign full     = level == LW'(FIFO_DEPTH);
    assign empty    = level == '0;

    // A full FIFO drops the sample even if a pop frees a slot this cycle.
    assign want = (state == FILL || state == WRITE) && din_en && !stop_now
                  && (RING || rx_cnt < depth);
    assign push = want && !full;
    assign drop = want && full;

    assign wr.wr_req  = (state == WRITE) && !empty;
    assign wr.wr_addr = base + offset;
    assign wr.wr_data = empty ? 16'h0 : mem[rd_ptr];
    assign pop        = wr.wr_req && wr.wr_valid;

    assign level_nx  = level + LW'(push) - LW'(pop);
    assign wr_cnt_nx = wr_cnt + 32'(pop);

    always_comb begin
        offset_nx = offset;
        if (pop) begin
            if (RING && offset == depth - 32'd1)
                offset_nx = '0;
            else
                offset_nx = offset + 32'd1;
        end
    end

    assign cap_busy = busy;
    assign cap_done = state == DONE;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (cap_start) begin
                    if (!sd_init_done)
                        state_nx = WAIT_INIT;
                    else if (cap_depth == '0)
                        state_nx = DONE;
                    else
                        state_nx = FILL;
                end
            end
            WAIT_INIT: begin
                if (stop_now)
                    state_nx = DONE;
                else if (sd_init_done)
                    state_nx = (depth == '0) ? DONE : FILL;
            end
            FILL: begin
                if (stop_now)
                    state_nx = empty ? DONE : WRITE;
                else if (level >= LW'(BURST_TH) ||
                         (!empty && !RING && rx_cnt == depth))
                    state_nx = WRITE;
            end
            WRITE: begin
                if ((!RING && wr_cnt_nx == depth) ||
                    (stop_now && level_nx == '0))
                    state_nx = DONE;
                else if (level_nx == '0)
                    state_nx = FILL;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge sdram_clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            base     <= '0;
            depth    <= '0;
            offset   <= '0;
            rx_cnt   <= '0;
            wr_cnt   <= '0;
            stopping <= 1'b0;
            fifo_ovf <= 1'b0;
        end else if (start) begin
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            base     <= cap_base;
            depth    <= cap_depth;
            offset   <= '0;
            rx_cnt   <= '0;
            wr_cnt   <= '0;
            stopping <= 1'b0;
            fifo_ovf <= 1'b0;
        end else begin
            level <= level_nx;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rx_cnt <= rx_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                offset <= offset_nx;
                wr_cnt <= wr_cnt_nx;
            end
            if (drop)
                fifo_ovf <= 1'b1;
            if (busy && cap_stop)
                stopping <= 1'b1;
        end
    end
endmodule
